src_reg_sel: RTL and testbench
==============================

// Module: src_reg_sel
// PURPOSE
//  Read-side counterpart of the destination register selector: drains a DEPTH-entry rotating
//  register bank in the same order the writer fills it. Tracks occupancy from the writer's load
//  strobe, drives a one-hot source select, and captures the selected entry. Presents the captured
//  word on a valid/ready output port to the consuming datapath.
// PARAMETERS
//  WIDTH   8  data width of one bank entry
//  DEPTH   3  number of bank entries (one-hot select width), >=2
// PORTS
//  CLK        in   1                    clock; all state updates on rising edge
//  RST        in   1                    synchronous, active-low reset
//  LDD        in   1                    writer load strobe, one-cycle pulse per bank write
//  RD_DATA    in   WIDTH                bank read data, combinational from RSEL
//  RSEL       out  DEPTH                one-hot source select into bank
//  DOUT       out  WIDTH                captured output word
//  OUT_VALID  out  1                    DOUT holds an undelivered word
//  OUT_READY  in   1                    consumer accepts DOUT this cycle
//  FULL       out  1                    COUNT==DEPTH
//  EMPTY      out  1                    COUNT==0
//  OVF        out  1                    sticky: LDD arrived while full and no slot freed
// BEHAVIOUR
//  - Reset (RST==0 at edge): state IDLE, rd pointer=entry 0, COUNT=0, RSEL=0, DOUT=0,
//    OUT_VALID=0, OVF=0; FULL=0, EMPTY=1. Reset mid-transfer discards captured word.
//  - Order: entry 0 -> 1 -> ... -> DEPTH-1 -> 0, identical to writer sequence after reset.
//  - COUNT width $clog2(DEPTH+1). Per edge: +1 on accepted LDD, -1 on output handshake
//    (OUT_VALID & OUT_READY); both in same cycle -> unchanged.
//  - LDD while FULL: accepted if handshake in same cycle (COUNT stays DEPTH); else dropped,
//    COUNT unchanged, OVF set. OVF clears only on reset.
//  - FSM: IDLE -> FETCH when COUNT!=0. FETCH (1 cycle): RSEL=onehot(rd_ptr), DOUT<=RD_DATA
//    at end of cycle, -> HOLD with OUT_VALID=1. HOLD: DOUT, OUT_VALID stable until OUT_READY;
//    on handshake OUT_VALID<=0, rd_ptr advances (wrap DEPTH-1 -> 0), COUNT-1, -> IDLE.
//  - RSEL is all-zero in IDLE and HOLD; exactly one bit high in FETCH.
//  - Latency: LDD at edge n into empty block -> FETCH in cycle n+1 -> OUT_VALID=1 at n+2.
//    Back-to-back throughput: one word per 3 cycles with OUT_READY held high.
//  - Entry is freed at handshake, not at capture: writer never overwrites an undelivered word.
//  - OUT_READY ignored while OUT_VALID=0. LDD is a level sampled per edge; a 2-cycle pulse
//    counts as 2 writes.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE/FETCH/HOLD, 2 bits), reset constants.
//  - Sub-module src_ptr_ring: DEPTH-bit one-hot rotating pointer with advance enable and
//    synchronous reset to bit 0; reusable by writer side. Counter, FSM, and output register stay inline.
// TESTING
//  1 Reset: hold RST=0 2 cycles mid-HOLD -> OUT_VALID=0, RSEL=0, EMPTY=1, OVF=0, DOUT=0.
//  2 Single word: LDD pulse, RD_DATA=8'hA5 for entry 0 -> RSEL=3'b001 in cycle n+1,
//    DOUT=A5/OUT_VALID=1 at n+2; OUT_READY -> EMPTY=1 next cycle.
//  3 Fill: 3 LDD pulses, OUT_READY=0 -> FULL=1; 4th LDD -> OVF=1, COUNT stays 3.
//  4 Wrap: 4 writes/reads, bank {0:11,1:22,2:33} then 0:44 -> RSEL 001,010,100,001;
//    DOUT 11,22,33,44 in order.
//  5 Simultaneous: FULL, LDD and handshake same cycle -> COUNT=3, OVF=0, FULL stays 1.
//  6 Backpressure: OUT_READY=0 for 10 cycles in HOLD -> DOUT/OUT_VALID stable, RSEL=0.

Source files
------------

// File: rtl/src_reg_sel_pkg.sv
// Shared definitions for the source register selector and its pointer ring.
package src_reg_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_OVF   = 1'b0;

endpackage

// File: rtl/src_ptr_ring.sv
// One-hot rotating pointer; advances one position per enabled edge, resets to bit 0.
module src_ptr_ring #(
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  output logic [DEPTH-1:0] ptr_o
);

  localparam logic [DEPTH-1:0] PTR_RST = DEPTH'(1);

  logic [DEPTH-1:0] ptr_q;
  logic [DEPTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = {ptr_q[DEPTH-2:0], ptr_q[DEPTH-1]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= PTR_RST;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/src_reg_sel.sv
// Drains a rotating register bank in writer order and presents each entry on a valid/ready port.
//  state    | meaning
//  ST_IDLE  | no word held; wait for occupancy
//  ST_FETCH | select bank entry at rd pointer, capture at end of cycle
//  ST_HOLD  | captured word offered downstream until accepted
module src_reg_sel
  import src_reg_sel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ldd_i,
  input  logic [WIDTH-1:0] rd_data_i,
  output logic [DEPTH-1:0] rsel_o,
  output logic [WIDTH-1:0] dout_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o
);

  localparam int             CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic [DEPTH-1:0] rd_ptr;
  logic             hs;
  logic             ldd_acc;

  src_ptr_ring #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .adv_i  (hs),
    .ptr_o  (rd_ptr)
  );

  assign hs = (state_q == ST_HOLD) && out_ready_i;
  // A full bank still takes a write when the handshake frees a slot on the same edge.
  assign ldd_acc = ldd_i && ((cnt_q != CNT_FULL) || hs);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (ldd_acc && !hs)      cnt_d = cnt_q + CW'(1);
    else if (!ldd_acc && hs) cnt_d = cnt_q - CW'(1);
    if (ldd_i && !ldd_acc)   ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    rsel_o  = '0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q != '0) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rsel_o  = rd_ptr;
        dout_d  = rd_data_i;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      dout_q  <= '0;
      ovf_q   <= RST_OVF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout_o      = dout_q;
  assign out_valid_o = (state_q == ST_HOLD);
  assign full_o      = (cnt_q == CNT_FULL);
  assign empty_o     = (cnt_q == '0);
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_src_reg_sel.sv
// Directed bench for src_reg_sel: per-cycle vector table plus hand-written corner sequences.
module tb_src_reg_sel;

  logic       clk;
  logic       rst_n;
  logic       ldd;
  logic [7:0] rd_data;
  logic [2:0] rsel;
  logic [7:0] dout;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       empty;
  logic       ovf;

  logic [7:0] bank [3];
  int         wp;
  int         n_vec;
  int         n_err;

  src_reg_sel #(.WIDTH(8), .DEPTH(3)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ldd_i       (ldd),
    .rd_data_i   (rd_data),
    .rsel_o      (rsel),
    .dout_o      (dout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .full_o      (full),
    .empty_o     (empty),
    .ovf_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rd_data = 8'h00;
    if (rsel[0])      rd_data = bank[0];
    else if (rsel[1]) rd_data = bank[1];
    else if (rsel[2]) rd_data = bank[2];
  end

  typedef struct {
    logic       rst_n;
    logic       ldd;
    logic       wr;
    logic [7:0] wdata;
    logic       rdy;
    logic [2:0] e_rsel;
    logic       e_valid;
    logic [7:0] e_dout;
    logic       e_full;
    logic       e_empty;
    logic       e_ovf;
  } vec_t;

  vec_t vt [32];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Writer model: fills bank entries in the same rotating order as the DUT reads them.
  task automatic drive(input logic r, input logic l, input logic w, input logic [7:0] d, input logic rd);
    if (!r) wp = 0;
    if (w) begin
      bank[wp] = d;
      wp = (wp == 2) ? 0 : wp + 1;
    end
    rst_n     = r;
    ldd       = l;
    out_ready = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setv(input int i, input logic r, input logic l, input logic w, input logic [7:0] d,
                      input logic rd, input logic [2:0] es, input logic ev, input logic [7:0] ed,
                      input logic ef, input logic ee, input logic eo);
    vt[i] = '{r, l, w, d, rd, es, ev, ed, ef, ee, eo};
  endtask

  initial begin
    n_vec = 0; n_err = 0; wp = 0;
    rst_n = 1'b0; ldd = 1'b0; out_ready = 1'b0;
    bank[0] = 8'h00; bank[1] = 8'h00; bank[2] = 8'h00;

    //        rst ldd wr wdata rdy   rsel  v  dout  f  e  o
    setv( 0, 0, 0, 0, 8'h00, 0, 3'b000, 0, 8'h00, 0, 1, 0);
    setv( 1, 1, 1, 1, 8'hA5, 0, 3'b000, 0, 8'h00, 0, 0, 0);
    setv( 2, 1, 0, 0, 8'h00, 0, 3'b001, 0, 8'h00, 0, 0, 0);
    setv( 3, 1, 0, 0, 8'h00, 0, 3'b000, 1, 8'hA5, 0, 0, 0);
    setv( 4, 1, 0, 0, 8'h00, 1, 3'b000, 0, 8'hA5, 0, 1, 0);
    setv( 5, 0, 0, 0, 8'h00, 0, 3'b000, 0, 8'h00, 0, 1, 0);
    setv( 6, 1, 1, 1, 8'h11, 1, 3'b000, 0, 8'h00, 0, 0, 0);
    setv( 7, 1, 1, 1, 8'h22, 1, 3'b001, 0, 8'h00, 0, 0, 0);
    setv( 8, 1, 1, 1, 8'h33, 1, 3'b000, 1, 8'h11, 1, 0, 0);
    setv( 9, 1, 1, 1, 8'h44, 1, 3'b000, 0, 8'h11, 1, 0, 0);
    setv(10, 1, 0, 0, 8'h00, 1, 3'b010, 0, 8'h11, 1, 0, 0);
    setv(11, 1, 0, 0, 8'h00, 1, 3'b000, 1, 8'h22, 1, 0, 0);
    setv(12, 1, 0, 0, 8'h00, 1, 3'b000, 0, 8'h22, 0, 0, 0);
    setv(13, 1, 0, 0, 8'h00, 1, 3'b100, 0, 8'h22, 0, 0, 0);
    setv(14, 1, 0, 0, 8'h00, 1, 3'b000, 1, 8'h33, 0, 0, 0);
    setv(15, 1, 0, 0, 8'h00, 1, 3'b000, 0, 8'h33, 0, 0, 0);
    setv(16, 1, 0, 0, 8'h00, 1, 3'b001, 0, 8'h33, 0, 0, 0);
    setv(17, 1, 0, 0, 8'h00, 1, 3'b000, 1, 8'h44, 0, 0, 0);
    setv(18, 1, 0, 0, 8'h00, 1, 3'b000, 0, 8'h44, 0, 1, 0);
    setv(19, 0, 0, 0, 8'h00, 0, 3'b000, 0, 8'h00, 0, 1, 0);
    setv(20, 1, 1, 1, 8'hA1, 0, 3'b000, 0, 8'h00, 0, 0, 0);
    setv(21, 1, 1, 1, 8'hA2, 0, 3'b001, 0, 8'h00, 0, 0, 0);
    setv(22, 1, 1, 1, 8'hA3, 0, 3'b000, 1, 8'hA1, 1, 0, 0);
    setv(23, 1, 1, 0, 8'h00, 0, 3'b000, 1, 8'hA1, 1, 0, 1);
    setv(24, 1, 0, 0, 8'h00, 0, 3'b000, 1, 8'hA1, 1, 0, 1);
    setv(25, 1, 0, 0, 8'h00, 1, 3'b000, 0, 8'hA1, 0, 0, 1);
    setv(26, 1, 0, 0, 8'h00, 0, 3'b010, 0, 8'hA1, 0, 0, 1);
    setv(27, 1, 0, 0, 8'h00, 0, 3'b000, 1, 8'hA2, 0, 0, 1);
    setv(28, 1, 0, 0, 8'h00, 1, 3'b000, 0, 8'hA2, 0, 0, 1);
    setv(29, 1, 0, 0, 8'h00, 0, 3'b100, 0, 8'hA2, 0, 0, 1);
    setv(30, 1, 0, 0, 8'h00, 0, 3'b000, 1, 8'hA3, 0, 0, 1);
    setv(31, 1, 0, 0, 8'h00, 1, 3'b000, 0, 8'hA3, 0, 1, 1);

    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      drive(vt[i].rst_n, vt[i].ldd, vt[i].wr, vt[i].wdata, vt[i].rdy);
      chk("rsel",  i, 32'(rsel),      32'(vt[i].e_rsel));
      chk("valid", i, 32'(out_valid), 32'(vt[i].e_valid));
      chk("dout",  i, 32'(dout),      32'(vt[i].e_dout));
      chk("full",  i, 32'(full),      32'(vt[i].e_full));
      chk("empty", i, 32'(empty),     32'(vt[i].e_empty));
      chk("ovf",   i, 32'(ovf),       32'(vt[i].e_ovf));
    end

    // Backpressure: word sits in HOLD for 10 cycles with the consumer stalled.
    drive(1, 1, 1, 8'h5A, 0);
    drive(1, 0, 0, 8'h00, 0);
    chk("bp_fetch_rsel", 0, 32'(rsel), 32'h1);
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 0, 8'h00, 0);
      chk("bp_valid", c, 32'(out_valid), 32'h1);
      chk("bp_dout",  c, 32'(dout),      32'h5A);
      chk("bp_rsel",  c, 32'(rsel),      32'h0);
    end
    chk("bp_ovf_sticky", 0, 32'(ovf), 32'h1);

    // Reset held two cycles while a word is mid-HOLD discards it and clears OVF.
    drive(0, 0, 0, 8'h00, 1);
    drive(0, 0, 0, 8'h00, 1);
    chk("rst_valid", 0, 32'(out_valid), 32'h0);
    chk("rst_rsel",  0, 32'(rsel),      32'h0);
    chk("rst_empty", 0, 32'(empty),     32'h1);
    chk("rst_ovf",   0, 32'(ovf),       32'h0);
    chk("rst_dout",  0, 32'(dout),      32'h0);
    chk("rst_full",  0, 32'(full),      32'h0);

    // A two-cycle LDD level counts as two writes; both words drain in order.
    drive(1, 1, 1, 8'h61, 1);
    drive(1, 1, 1, 8'h62, 1);
    for (int w = 0; w < 2; w++) begin
      int budget;
      budget = 0;
      while (!out_valid && budget < 10) begin
        drive(1, 0, 0, 8'h00, 1);
        budget++;
      end
      chk("pulse2_timeout", w, 32'(out_valid), 32'h1);
      chk("pulse2_dout",    w, 32'(dout),      (w == 0) ? 32'h61 : 32'h62);
      drive(1, 0, 0, 8'h00, 1);
    end
    chk("pulse2_empty", 0, 32'(empty), 32'h1);
    chk("pulse2_ovf",   0, 32'(ovf),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
